// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the instruction fetch unit: fetch FSM
//                state encodings, MIPS opcode constants, PC step and the
//                default reset PC. Includes a helper that turns a branch
//                immediate into a byte offset.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE = 2'd0;
    localparam fetch_state_t FETCH_REQ  = 2'd1;
    localparam fetch_state_t FETCH_HOLD = 2'd2;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_BEQ           = 6'b000100;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sign-extend a 16-bit word offset and scale it to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC selection for the fetch stage.
//                Jump (JToPC) beats taken branch (Branch & Zero), which beats
//                sequential pc+4. All arithmetic wraps at 32 bits.
//  Ports       : i_if_pc    - address of the instruction being retired
//                i_if_instr - the instruction word itself
//                i_jtopc    - jump select from Control
//                i_branch   - branch select from Control
//                i_zero     - ALU zero flag
//                o_next_pc  - selected next fetch address
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] i_if_pc,
    input  logic [31:0] i_if_instr,
    input  logic        i_jtopc,
    input  logic        i_branch,
    input  logic        i_zero,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    // The opcode field does not influence the target; the decoder has already
    // folded it into JToPC/Branch.
    logic        w_unused_opcode;

    assign w_pc4           = i_if_pc + PC_STEP;
    // Jump keeps the 256 MB region of the delay-slot address (pc+4).
    assign w_jump_target   = {w_pc4[31:28], i_if_instr[25:0], 2'b00};
    assign w_branch_target = w_pc4 + branch_offset(i_if_instr[15:0]);
    assign w_unused_opcode = &{1'b0, i_if_instr[31:26]};

    always_comb begin
        o_next_pc = w_pc4;
        if (i_jtopc) begin
            o_next_pc = w_jump_target;
        end else if (i_branch && i_zero) begin
            o_next_pc = w_branch_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Owns the PC, fetches instruction words over a req/ack memory
//                port and holds each word for the decoder with valid/ready.
//                On acceptance the next PC is chosen from JToPC/Branch/Zero.
//  Ports       : clk, reset               - clock, async active-high reset
//                fetch_en                 - allow new fetches
//                imem_req/addr/ack/rdata  - instruction memory port
//                if_valid/ready           - handshake to the decoder
//                if_instr/Opcode/Funct    - held word and its fields
//                if_pc                    - address of the held word
//                JToPC, Branch, Zero      - next-PC controls (accept cycle only)
//                instr_count              - accepted instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic [31:0] if_pc,
    input  logic        JToPC,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] instr_count
);

    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state_q;
    fetch_state_t w_state_d;

    logic [31:0] r_pc_q,     w_pc_d;
    logic [31:0] r_instr_q,  w_instr_d;
    logic [31:0] r_if_pc_q,  w_if_pc_d;
    logic [31:0] r_count_q,  w_count_d;

    logic [31:0] w_next_pc;
    logic        w_ack_take;
    logic        w_accept;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= FETCH_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            FETCH_IDLE: if (fetch_en) w_state_d = FETCH_REQ;
            // fetch_en is deliberately ignored here: an issued request
            // always completes so the memory handshake is never torn.
            FETCH_REQ:  if (imem_ack) w_state_d = FETCH_HOLD;
            FETCH_HOLD: if (if_ready) w_state_d = fetch_en ? FETCH_REQ : FETCH_IDLE;
            default:    w_state_d = FETCH_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        if_valid = 1'b0;
        case (r_state_q)
            FETCH_REQ:  imem_req = 1'b1;
            FETCH_HOLD: if_valid = 1'b1;
            default: begin
                imem_req = 1'b0;
                if_valid = 1'b0;
            end
        endcase
    end

    assign w_ack_take = (r_state_q == FETCH_REQ)  && imem_ack;
    assign w_accept   = (r_state_q == FETCH_HOLD) && if_ready;

    pc_next_calc u_pc_next_calc (
        .i_if_pc    (r_if_pc_q),
        .i_if_instr (r_instr_q),
        .i_jtopc    (JToPC),
        .i_branch   (Branch),
        .i_zero     (Zero),
        .o_next_pc  (w_next_pc)
    );

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_if_pc_d = r_if_pc_q;
        w_count_d = r_count_q;
        if (w_ack_take) begin
            w_instr_d = imem_rdata;
            w_if_pc_d = r_pc_q;
        end
        if (w_accept) begin
            w_pc_d    = {w_next_pc[31:2], 2'b00};
            w_count_d = r_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_q    <= c_reset_pc;
            r_instr_q <= 32'h0000_0000;
            r_if_pc_q <= c_reset_pc;
            r_count_q <= 32'h0000_0000;
        end else begin
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_if_pc_q <= w_if_pc_d;
            r_count_q <= w_count_d;
        end
    end

    assign imem_addr   = r_pc_q;
    assign if_instr    = r_instr_q;
    assign Opcode      = r_instr_q[31:26];
    assign Funct       = r_instr_q[5:0];
    assign if_pc       = r_if_pc_q;
    assign instr_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A reference model
//                tracks the expected PC, held word and accept count; directed
//                steps cover sequential flow, branches, jumps, stalls,
//                fetch_en drop, PC wrap and reset mid-request, followed by
//                randomized transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [31:0] if_pc;
    logic        JToPC;
    logic        Branch;
    logic        Zero;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_instr;
    logic [31:0] m_if_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .if_pc       (if_pc),
        .JToPC       (JToPC),
        .Branch      (Branch),
        .Zero        (Zero),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic j, input logic b, input logic z);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
        if (b && z) begin
            off = int'($signed(instr[15:0]));
            return pc4 + 32'(off * 4);
        end
        return pc4;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("req_arrives", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] word, input int ack_dly);
        wait_req();
        check("req_addr", imem_addr, m_pc);
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr = word;
        m_if_pc = m_pc;
        check("valid_after_ack", {31'd0, if_valid}, 32'd1);
        check("req_drop_hold", {31'd0, imem_req}, 32'd0);
        check("if_instr", if_instr, m_instr);
        check("if_pc", if_pc, m_if_pc);
        check("opcode", {26'd0, Opcode}, m_instr >> 26);
        check("funct", {26'd0, Funct}, m_instr & 32'h3F);
    endtask

    task automatic accept(input int rdy_dly, input logic j, input logic b, input logic z,
                          input logic en_after);
        for (int i = 0; i < rdy_dly; i++) begin
            if_ready = 1'b0;
            JToPC    = 1'($urandom);
            Branch   = 1'($urandom);
            Zero     = 1'($urandom);
            @(negedge clk);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_instr", if_instr, m_instr);
            check("stall_pc", if_pc, m_if_pc);
            check("stall_noreq", {31'd0, imem_req}, 32'd0);
            check("stall_count", instr_count, m_count);
        end
        if_ready = 1'b1;
        JToPC    = j;
        Branch   = b;
        Zero     = z;
        fetch_en = en_after;
        @(negedge clk);
        if_ready = 1'b0;
        JToPC    = 1'($urandom);
        Branch   = 1'($urandom);
        Zero     = 1'($urandom);
        m_pc     = ref_next(m_if_pc, m_instr, j, b, z);
        m_count  = m_count + 32'd1;
        check("count", instr_count, m_count);
        check("valid_drop", {31'd0, if_valid}, 32'd0);
        check("pc_model", imem_addr, m_pc);
    endtask

    initial begin
        reset      = 1'b1;
        fetch_en   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        if_ready   = 1'b0;
        JToPC      = 1'b0;
        Branch     = 1'b0;
        Zero       = 1'b0;
        m_pc = 32'd0; m_count = 32'd0; m_instr = 32'd0; m_if_pc = 32'd0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_opcode", {26'd0, Opcode}, 32'd0);
        check("rst_funct", {26'd0, Funct}, 32'd0);

        reset    = 1'b0;
        fetch_en = 1'b1;

        // add $2,$4,$5 at address 0, ack in first REQ cycle
        fetch(32'h0085_1020, 0);
        check("t1_funct", {26'd0, Funct}, 32'h20);
        check("t1_opcode", {26'd0, Opcode}, 32'h0);
        check("t1_if_pc", if_pc, 32'h0);

        // Sequential flow
        accept(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_addr4", imem_addr, 32'h4);
        fetch(32'h0000_0020, 0);
        accept(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_addr8", imem_addr, 32'h8);
        check("t2_count2", instr_count, 32'd2);
        fetch(32'h0000_0020, 0); accept(0, 1'b0, 1'b0, 1'b0, 1'b1);
        fetch(32'h0000_0020, 0); accept(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_at10", imem_addr, 32'h10);

        // beq at 0x10 not taken -> 0x14
        fetch(32'h1000_0003, 0); accept(0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_beq_nt", imem_addr, 32'h14);
        // back-branch at 0x14 with offset -2 -> 0x10
        fetch(32'h1000_FFFE, 0); accept(0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t3_back", imem_addr, 32'h10);
        // imm 0xFFFF taken at 0x10 -> 0x10
        fetch(32'h1000_FFFF, 0); accept(0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t3_self", imem_addr, 32'h10);
        // beq imm 3 taken at 0x10 -> 0x20
        fetch(32'h1000_0003, 0); accept(0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t3_beq_t", imem_addr, 32'h20);

        // Jumps: 0x20 -> 0x100 -> 0x200 -> 0x100 -> 0x200 (jump beats branch)
        fetch(32'h0800_0040, 0); accept(0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_to100", imem_addr, 32'h100);
        fetch(32'h0800_0080, 0); accept(0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_j200", imem_addr, 32'h200);
        fetch(32'h0800_0040, 0); accept(0, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch(32'h0800_0080, 0); accept(0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_jprio", imem_addr, 32'h200);

        // Stalls on both sides
        fetch(32'h0000_0020, 3);
        accept(5, 1'b0, 1'b0, 1'b0, 1'b1);

        // fetch_en falls during REQ: word completes, then idle
        fetch_en = 1'b0;
        fetch(32'h0000_0020, 1);
        accept(0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_noreq", {31'd0, imem_req}, 32'd0);
            check("idle_novalid", {31'd0, if_valid}, 32'd0);
        end
        fetch_en = 1'b1;

        // PC wrap: jump to 0, branch back to 0xFFFF_FFFC, then sequential
        fetch(32'h0800_0000, 0); accept(0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t6_at0", imem_addr, 32'h0);
        fetch(32'h1000_FFFE, 0); accept(0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t6_top", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0020, 0); accept(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_wrap", imem_addr, 32'h0);

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            fetch($urandom, int'($urandom_range(0, 3)));
            accept(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            check("addr_align", imem_addr & 32'h3, 32'h0);
        end

        // Reset in the middle of a request
        wait_req();
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_count", instr_count, 32'd0);
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("late_ack_valid", {31'd0, if_valid}, 32'd0);
        check("late_ack_instr", if_instr, 32'd0);
        check("late_ack_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        m_pc = 32'd0; m_count = 32'd0;

        // Resumes from the reset PC
        fetch_en = 1'b1;
        fetch(32'h0085_1020, 2);
        accept(1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("resume_addr", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
